pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-field ID/EX latch. It carries an opaque packed payload of DATA_W bits between two pipeline stages using a valid/ready handshake. It supports hazard hold (bubble), flush and stall-cycle counting, plus an optional skid slot that registers in_ready. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives hold and the branch/exception logic drives flush.

## Interface
- DATA_W, 64: payload width in bits; the stage packs its control fields into this vector.
- CNT_W, 32: stall counter width.
- CLEAR_DATA, 1: 1 zeroes payload slots on flush/reset; 0 leaves payload untouched and clears only the valid bits.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- hold  in  1  hazard freeze: no dequeue, no enqueue; contents are kept.
- flush  in  1  discard all held payloads.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and no dequeue.

## Operation
- Priority: rst > flush > hold > normal. Flush beats hold; the old latch gave bubble priority, and that ordering is not retained.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready & ~hold.
- Main slot (main_v, main_d) is always the head; out_valid = main_v and out_data = main_d.
- Without skid: in_ready = ~hold & ~flush & (~main_v | out_ready). On in_fire, the main slot loads in_data. On out_fire without in_fire, main_v clears.
- With skid, in_ready = ~skid_v, taken from a register and independent of out_ready/hold. On in_fire:
  - the payload goes to main if main will be empty after this cycle (~main_v or out_fire) and skid is empty;
  - otherwise it goes to skid.
- With skid, on out_fire while skid_v: skid moves to main, and skid_v clears unless an in_fire refills it.
- Ordering is strictly FIFO; no payload is dropped or duplicated.
- hold=1: all slots keep their contents. Without skid, in_ready=0. With skid, an in_fire while skid is empty is still accepted into skid, or into main if main is empty.
- flush=1: main_v=0 and skid_v=0. Payload registers are zeroed if CLEAR_DATA=1. An in_fire in the same cycle is discarded (in_ready is forced to 0 in non-skid mode; in skid mode the accepted beat is dropped by the flush).
- stall_cnt increments when out_valid & ~out_fire, saturates at all-ones, and is cleared only by rst; flush does not clear it.

## Timing
- Reset values: out_valid=0, out_data=0, stall_cnt=0. in_ready=0 during the reset cycle and 1 on the first cycle after rst deasserts.
- Latency: in_fire at edge N gives out_valid=1 with that data from edge N (visible in cycle N+1).
- Throughput is 1 beat/cycle with out_ready held high, in both modes.
- Without skid, in_ready has a combinational path from out_ready and hold; with skid it does not.
- rst or flush asserted mid-transfer takes effect at the same edge; no partial state remains.

## Configuration
- PIPE_SKID_EN defined: the second slot exists, in_ready is a pure register output, and capacity is 2.
- PIPE_SKID_EN undefined: single slot, combinational in_ready, capacity 1, and the skid registers are not synthesised.

## Structure
- Shared package pipe_pkg holds:
  - per-stage payload struct typedefs (id_ex_t and similar) with their $bits width constants, used as DATA_W at instantiation;
  - localparam STALL_CNT_W_DEFAULT.
- One natural sub-module, pipe_sat_counter: a saturating CNT_W counter with an inc input and sync reset, reusable for the other performance counters.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAA → out_valid=0, out_data=0, stall_cnt=0; cycle after release → in_ready=1.
- Streaming: out_ready=1, push 0x1,0x2,0x3 back-to-back → out_data 0x1,0x2,0x3 on consecutive cycles at 1-cycle latency, stall_cnt=0.
- Backpressure (skid): hold 0x10 at head with out_ready=0 and push 0x11 → in_ready drops to 0 the next cycle; release → 0x10 then 0x11, stall_cnt increments by the stalled cycle count.
- Hold: head 0x55, hold=1 for 3 cycles with out_ready=1 → out_data stays 0x55, no dequeue, stall_cnt +3.
- Flush vs hold: hold=1, flush=1, in_valid=1 with 0x77 in the same cycle → next cycle out_valid=0, out_data=0 (CLEAR_DATA=1), 0x77 absent downstream.
- Saturation: CNT_W=4, 20 stalled cycles → stall_cnt=0xF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: per-stage payload structs,
// their packed widths and the default performance-counter width.
package pipe_pkg;

  localparam int STALL_CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous reset; shared by the pipeline
// performance counters.
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with hold, flush and a stall counter.
// Define PIPE_SKID_EN to add a second (skid) slot and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CNT_W      = STALL_CNT_W_DEFAULT,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v_q;
  logic              main_v_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic              in_fire;
  logic              out_fire;
  logic              clear;
  logic              stall_inc;

  assign clear    = rst | flush;
  assign out_fire = main_v_q & out_ready & ~hold;
  assign in_fire  = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_v_q;
  logic              skid_v_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;

  // Only the skid flag (and the sync reset) gate acceptance, so upstream
  // sees no combinational path from out_ready or hold.
  assign in_ready = ~skid_v_q & ~rst;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (clear) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      if (out_fire) begin
        main_v_d = skid_v_q;
        if (skid_v_q) begin
          main_data_d = skid_data_q;
          skid_v_d    = 1'b0;
        end
      end
      if (in_fire) begin
        if ((~main_v_q | out_fire) & ~skid_v_q) begin
          main_v_d    = 1'b1;
          main_data_d = in_data;
        end else begin
          skid_v_d    = 1'b1;
          skid_data_d = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    skid_v_q    <= skid_v_d;
    skid_data_q <= skid_data_d;
  end
`else
  assign in_ready = ~rst & ~hold & ~flush & (~main_v_q | out_ready);

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    if (clear) begin
      main_v_d = 1'b0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
      end
    end else if (in_fire) begin
      main_v_d    = 1'b1;
      main_data_d = in_data;
    end else if (out_fire) begin
      main_v_d = 1'b0;
    end
  end
`endif

  // NOTE: payload registers are only reset when CLEAR_DATA asks for it; the
  // valid bits alone define occupancy, so stale data is harmless otherwise.
  always_ff @(posedge clk) begin
    main_v_q    <= main_v_d;
    main_data_q <= main_data_d;
  end

  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign stall_inc = main_v_q & ~out_fire;

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

endmodule
